seg_display_scanner: RTL

//  Time-multiplexed driver for an N-digit common-anode 7-segment display (active-low anodes and segments).

---
 rtl/seg_display_scanner_pkg.sv | 32 +++
 rtl/seg_display_scanner_if.sv | 28 ++
 rtl/seg_display_scanner_hex_seg_decode.sv | 13 +
 rtl/seg_display_scanner.sv | 124 ++++++++++++
 4 files changed

// File: rtl/seg_display_scanner_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scanner.
// Patterns are active high, {a,b,c,d,e,f,g,dp} with a in bit 7.
package seg_display_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    function automatic seg_t hex_pattern(input logic [3:0] d);
        seg_t p;
        case (d)
            4'h0:    p = 8'hFC;
            4'h1:    p = 8'h60;
            4'h2:    p = 8'hDA;
            4'h3:    p = 8'hF2;
            4'h4:    p = 8'h66;
            4'h5:    p = 8'hB6;
            4'h6:    p = 8'hBE;
            4'h7:    p = 8'hE0;
            4'h8:    p = 8'hFE;
            4'h9:    p = 8'hF6;
            4'hA:    p = 8'hEE;
            4'hB:    p = 8'h3E;
            4'hC:    p = 8'h9C;
            4'hD:    p = 8'h7A;
            4'hE:    p = 8'h9E;
            default: p = 8'h8E;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Data/load bus into the scanner and the display pin bundle out of it.
// master = register side driving the snapshot, slave = the scanner.
interface seg_display_scanner_if
    import seg_display_pkg::*;
#(
    parameter int NDIGITS = 8
);

    logic                   load;
    logic [4*NDIGITS-1:0]   value;
    logic [NDIGITS-1:0]     dp;
    logic [NDIGITS-1:0]     digit_en;
    logic                   lzs;
    logic [NDIGITS-1:0]     digitselect;
    seg_t                   segments;
    logic                   slot_tick;

    modport master (
        output load, value, dp, digit_en, lzs,
        input  digitselect, segments, slot_tick
    );

    modport slave (
        input  load, value, dp, digit_en, lzs,
        output digitselect, segments, slot_tick
    );

endinterface

// File: rtl/seg_display_scanner_hex_seg_decode.sv
// One hex digit plus decimal point to active-low segment drive.
// Purely combinational; the scanner registers the result.
module hex_seg_decode
    import seg_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output seg_t       seg
);

    assign seg = ~(hex_pattern(digit) | {7'b0, dp});

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode 7-segment driver with shadow snapshot,
// leading-zero suppression and a dark guard interval at each slot start.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int NDIGITS       = 8,
    parameter int PRESCALE_BITS = 17,
    parameter int GUARD         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    seg_display_scanner_if.slave bus
);

    localparam int IW = $clog2(NDIGITS);
    localparam int VW = 4 * NDIGITS;
    localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

    logic [PRESCALE_BITS-1:0] cnt;
    logic [IW-1:0]            idx;
    logic                     tick;
    logic                     in_guard;

    logic [VW-1:0]            val_q;
    logic [NDIGITS-1:0]       dp_q;
    logic [NDIGITS-1:0]       en_q;
    logic                     lzs_q;

    logic [NDIGITS-1:0]       supp;
    logic [3:0]               nib;
    logic                     cur_dp;
    logic                     cur_en;
    logic                     cur_supp;
    seg_t                     dec_seg;

    logic [NDIGITS-1:0]       sel_d;
    seg_t                     seg_d;
    logic [NDIGITS-1:0]       sel_q;
    seg_t                     seg_q;
    logic                     tick_q;

    assign tick = &cnt;

    if (GUARD == 0) begin : g_noguard
        assign in_guard = 1'b0;
    end else begin : g_guard
        assign in_guard = cnt < PRESCALE_BITS'(GUARD);
    end

    // A digit is blank when it and everything left of it is zero with no dp.
    always_comb begin
        logic run;
        supp = '0;
        run  = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            run     = run && (val_q[4*i +: 4] == 4'h0) && !dp_q[i];
            supp[i] = run && lzs_q && (i != 0);
        end
    end

    always_comb begin
        nib      = '0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib      = val_q[4*i +: 4];
                cur_dp   = dp_q[i];
                cur_en   = en_q[i];
                cur_supp = supp[i];
            end
        end
    end

    hex_seg_decode u_dec (
        .digit (nib),
        .dp    (cur_dp),
        .seg   (dec_seg)
    );

    // Blank digits keep their anode on so every slot draws the same timing.
    always_comb begin
        sel_d = '1;
        seg_d = SEG_OFF;
        if (!in_guard) begin
            sel_d = ~(NDIGITS'(1) << idx);
            if (cur_en && !cur_supp)
                seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            val_q  <= '0;
            dp_q   <= '0;
            en_q   <= '0;
            lzs_q  <= 1'b0;
            sel_q  <= '1;
            seg_q  <= SEG_OFF;
            tick_q <= 1'b0;
        end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= tick;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
            if (tick)
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            if (bus.load) begin
                val_q <= bus.value;
                dp_q  <= bus.dp;
                en_q  <= bus.digit_en;
                lzs_q <= bus.lzs;
            end
        end
    end

    assign bus.digitselect = sel_q;
    assign bus.segments    = seg_q;
    assign bus.slot_tick   = tick_q;

endmodule
